// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin arbiter sharing one Wishbone memory port between iwb and dwb
module wb_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction bus
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  // data bus
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  // shared memory port
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // Instruction returned to the core when a fetch fails or times out (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  // Last wait count value before a stalled grant is forced to complete.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        req_i, req_d;
  logic        timeout;

  assign req_i   = iwb_cyc_i & iwb_stb_i;
  assign req_d   = dwb_cyc_i & dwb_stb_i;
  assign timeout = (wait_cnt_q == TMO_LAST);

  // State, round-robin pointer and wait counter; reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LG_D;
      wait_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Wait counter restarts for every grant and counts cycles spent without a response.
  always_comb begin
    wait_cnt_d = 16'd0;
    if (state_q != IDLE && state_d != IDLE) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  // Grant selection, next state and all bus outputs, derived from the current state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iwb_dat_o    = 32'd0;
    iwb_ack_o    = 1'b0;
    dwb_dat_o    = 32'd0;
    dwb_ack_o    = 1'b0;
    dwb_err_o    = 1'b0;
    m_adr_o      = 32'd0;
    m_dat_o      = 32'd0;
    m_we_o       = 1'b0;
    m_sel_o      = 4'd0;
    m_cyc_o      = 1'b0;
    m_stb_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          if (last_grant_q == LG_D) begin
            state_d      = GNT_I;
            last_grant_d = LG_I;
          end else begin
            state_d      = GNT_D;
            last_grant_d = LG_D;
          end
        end else if (req_i) begin
          state_d      = GNT_I;
          last_grant_d = LG_I;
        end else if (req_d) begin
          state_d      = GNT_D;
          last_grant_d = LG_D;
        end
      end

      GNT_I: begin
        m_adr_o   = iwb_adr_i;
        m_sel_o   = 4'hF;
        m_cyc_o   = 1'b1;
        m_stb_o   = 1'b1;
        iwb_dat_o = m_dat_i;
        if (!iwb_cyc_i) begin
          // requester walked away: drop the grant silently
          state_d = IDLE;
        end else if (m_err_i) begin
          iwb_ack_o = 1'b1;
          iwb_dat_o = NOP_INSN;
          state_d   = IDLE;
        end else if (m_ack_i) begin
          iwb_ack_o = 1'b1;
          state_d   = IDLE;
        end else if (timeout) begin
          iwb_ack_o = 1'b1;
          iwb_dat_o = NOP_INSN;
          state_d   = IDLE;
        end
      end

      GNT_D: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_we_o    = dwb_we_i;
        m_sel_o   = dwb_sel_i;
        m_cyc_o   = 1'b1;
        m_stb_o   = 1'b1;
        dwb_dat_o = m_dat_i;
        if (!dwb_cyc_i) begin
          state_d = IDLE;
        end else if (m_err_i) begin
          dwb_err_o = 1'b1;
          state_d   = IDLE;
        end else if (m_ack_i) begin
          dwb_ack_o = 1'b1;
          state_d   = IDLE;
        end else if (timeout) begin
          dwb_err_o = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - directed self-checking bench for wb_mem_arbiter
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i, iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic [31:0] dwb_adr_i, dwb_dat_i;
  logic        dwb_we_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_cyc_i, dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o, dwb_err_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i;

  int checks = 0;
  int errors = 0;

  wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
    .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    iwb_adr_i = 32'd0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    dwb_adr_i = 32'd0; dwb_dat_i = 32'd0; dwb_we_i = 1'b0; dwb_sel_i = 4'd0;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    m_dat_i = 32'd0; m_ack_i = 1'b0; m_err_i = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = 32'h55;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_adr_o !== 32'd0 || m_sel_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_m_outputs: cyc=%b stb=%b adr=%h sel=%h, expected all 0", m_cyc_o, m_stb_o, m_adr_o, m_sel_o);
    end
    tick(); tick();
    checks++;
    if (m_cyc_o !== 1'b0 || iwb_ack_o !== 1'b0 || dwb_ack_o !== 1'b0 || dwb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: cyc=%b iack=%b dack=%b derr=%b, expected 0", m_cyc_o, iwb_ack_o, dwb_ack_o, dwb_err_o);
    end
    clear_inputs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_ifetch;
    do_reset();
    iwb_adr_i = 32'h4; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    #1;
    checks++;
    if (m_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_no_early_grant: stb=%b expected 0", m_stb_o);
    end
    tick();
    checks++;
    if (m_cyc_o !== 1'b1 || m_stb_o !== 1'b1 || m_adr_o !== 32'h4 || m_sel_o !== 4'hF ||
        m_we_o !== 1'b0 || m_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL ifetch_grant: cyc=%b stb=%b adr=%h sel=%h we=%b dat=%h, expected 1 1 4 f 0 0",
               m_cyc_o, m_stb_o, m_adr_o, m_sel_o, m_we_o, m_dat_o);
    end
    tick();
    m_ack_i = 1'b1; m_dat_i = 32'h0020D733;
    #1;
    checks++;
    if (iwb_ack_o !== 1'b1 || iwb_dat_o !== 32'h0020D733 || dwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_ack: iack=%b idat=%h dack=%b, expected 1 0020d733 0", iwb_ack_o, iwb_dat_o, dwb_ack_o);
    end
    tick();
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || iwb_ack_o !== 1'b0 || iwb_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL ifetch_idle_ignores_ack: cyc=%b iack=%b idat=%h, expected 0 0 0", m_cyc_o, iwb_ack_o, iwb_dat_o);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    logic exp_i [4];
    exp_i[0] = 1'b1; exp_i[1] = 1'b0; exp_i[2] = 1'b1; exp_i[3] = 1'b0;
    do_reset();
    iwb_adr_i = 32'h1000; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    dwb_adr_i = 32'h2000; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (m_cyc_o !== 1'b1 || m_adr_o !== (exp_i[k] ? 32'h1000 : 32'h2000)) begin
        errors++;
        $display("FAIL rr_grant_%0d: cyc=%b adr=%h, expected 1 %h", k, m_cyc_o, m_adr_o,
                 exp_i[k] ? 32'h1000 : 32'h2000);
      end
      m_ack_i = 1'b1;
      #1;
      checks++;
      if (iwb_ack_o !== exp_i[k] || dwb_ack_o !== !exp_i[k]) begin
        errors++;
        $display("FAIL rr_ack_%0d: iack=%b dack=%b, expected %b %b", k, iwb_ack_o, dwb_ack_o, exp_i[k], !exp_i[k]);
      end
      tick();
      m_ack_i = 1'b0;
      #1;
      checks++;
      if (m_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_gap_%0d: cyc=%b expected 0", k, m_cyc_o);
      end
    end
    clear_inputs();
  endtask

  task automatic test_write;
    do_reset();
    dwb_adr_i = 32'h100; dwb_dat_i = 32'hDEADBEEF; dwb_we_i = 1'b1; dwb_sel_i = 4'b0011;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    tick();
    checks++;
    if (m_we_o !== 1'b1 || m_sel_o !== 4'b0011 || m_dat_o !== 32'hDEADBEEF || m_adr_o !== 32'h100 ||
        dwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL write_drive: we=%b sel=%b dat=%h adr=%h dack=%b, expected 1 0011 deadbeef 100 0",
               m_we_o, m_sel_o, m_dat_o, m_adr_o, dwb_ack_o);
    end
    m_ack_i = 1'b1;
    #1;
    checks++;
    if (dwb_ack_o !== 1'b1 || dwb_err_o !== 1'b0 || iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: dack=%b derr=%b iack=%b, expected 1 0 0", dwb_ack_o, dwb_err_o, iwb_ack_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout;
    int first_err;
    do_reset();
    dwb_adr_i = 32'h200; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    first_err = 0;
    // stb rises on grant cycle 1; forced error is due on grant cycle 8
    for (int c = 1; c <= 9 && first_err == 0; c++) begin
      tick();
      if (dwb_err_o === 1'b1) first_err = c;
    end
    checks++;
    if (first_err != 8) begin
      errors++;
      $display("FAIL timeout_cycle: err seen at grant cycle %0d, expected 8", first_err);
    end
    checks++;
    if (dwb_ack_o !== 1'b0 || m_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flags: dack=%b stb=%b, expected 0 1", dwb_ack_o, m_stb_o);
    end
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    tick();
    checks++;
    if (m_cyc_o !== 1'b0 || dwb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: cyc=%b derr=%b, expected 0 0", m_cyc_o, dwb_err_o);
    end
    // instruction side: stalled fetch is completed with a NOP
    iwb_adr_i = 32'h40; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    for (int c = 1; c <= 7; c++) tick();
    checks++;
    if (iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL itimeout_early: iack=%b at grant cycle 7, expected 0", iwb_ack_o);
    end
    tick();
    checks++;
    if (iwb_ack_o !== 1'b1 || iwb_dat_o !== 32'h00000013) begin
      errors++;
      $display("FAIL itimeout_nop: iack=%b idat=%h, expected 1 00000013", iwb_ack_o, iwb_dat_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_errors;
    do_reset();
    dwb_adr_i = 32'h300; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    tick();
    m_ack_i = 1'b1; m_err_i = 1'b1; m_dat_i = 32'h12345678;
    #1;
    checks++;
    if (dwb_err_o !== 1'b1 || dwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL derr_precedence: derr=%b dack=%b, expected 1 0", dwb_err_o, dwb_ack_o);
    end
    tick();
    clear_inputs();
    iwb_adr_i = 32'h80; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    tick();
    m_err_i = 1'b1; m_dat_i = 32'hFFFFFFFF;
    #1;
    checks++;
    if (iwb_ack_o !== 1'b1 || iwb_dat_o !== 32'h00000013 || dwb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ierr_nop: iack=%b idat=%h derr=%b, expected 1 00000013 0", iwb_ack_o, iwb_dat_o, dwb_err_o);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    dwb_adr_i = 32'h400; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    tick();
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; m_ack_i = 1'b1;
    #1;
    checks++;
    if (dwb_ack_o !== 1'b0 || dwb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ack: dack=%b derr=%b, expected 0 0", dwb_ack_o, dwb_err_o);
    end
    tick();
    m_ack_i = 1'b0;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: cyc=%b expected 0", m_cyc_o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    dwb_adr_i = 32'h500; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    tick();
    iwb_adr_i = 32'h600; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    #1;
    checks++;
    if (m_adr_o !== 32'h500 || m_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: adr=%h cyc=%b, expected 500 1", m_adr_o, m_cyc_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: cyc=%b stb=%b, expected 0 0", m_cyc_o, m_stb_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 32'h600) begin
      errors++;
      $display("FAIL midrst_iwb_first: cyc=%b adr=%h, expected 1 600", m_cyc_o, m_adr_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_ifetch();
    test_round_robin();
    test_write();
    test_timeout();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
